// File: rtl/icache_pkg.sv
// Shared types and address-geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        FILL_DONE
    } icache_state_t;

    localparam int DEF_LINES       = 8;
    localparam int DEF_BLOCK_WORDS = 4;

    function automatic int off_bits(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Tag covers everything above the byte offset, word offset and index fields.
    function automatic int tag_bits(input int lines, input int block_words);
        return 30 - $clog2(lines) - $clog2(block_words);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational lookup port, one word write port, tag/valid set and flush-all.
module icache_array
    import icache_pkg::*;
#(
    parameter int  LINES       = DEF_LINES,
    parameter int  BLOCK_WORDS = DEF_BLOCK_WORDS,
    localparam int OFF_W       = off_bits(BLOCK_WORDS),
    localparam int IDX_W       = idx_bits(LINES),
    localparam int TAG_W       = tag_bits(LINES, BLOCK_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [OFF_W-1:0] rd_word,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [OFF_W-1:0] wr_word,
    input  logic [31:0]      wr_data,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             flush_all
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES][BLOCK_WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (flush_all) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays carry no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_index][wr_word] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    assign rd_hit  = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
    assign rd_data = data_mem[rd_index][rd_word];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: lookup, bypass, whole-line refill FSM and flush handling.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int LINES       = DEF_LINES,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        cache_en,
    input  logic        flush,
    output logic [31:0] instruction,
    output logic        hit,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int OFF_W = off_bits(BLOCK_WORDS);
    localparam int IDX_W = idx_bits(LINES);
    localparam int TAG_W = tag_bits(LINES, BLOCK_WORDS);

    icache_state_t    state, next_state;
    logic [OFF_W-1:0] word_cnt;
    logic [31:0]      base_addr;
    logic             flush_pend;
    logic             start_miss;
    logic             wr_en;
    logic             tag_we;
    logic             flush_all;
    logic             lookup_hit;
    logic [31:0]      lookup_data;

    icache_array #(
        .LINES       (LINES),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (pc[2+OFF_W +: IDX_W]),
        .rd_word   (pc[2 +: OFF_W]),
        .rd_tag    (pc[31 -: TAG_W]),
        .rd_hit    (lookup_hit),
        .rd_data   (lookup_data),
        .wr_en     (wr_en),
        .wr_index  (base_addr[2+OFF_W +: IDX_W]),
        .wr_word   (word_cnt),
        .wr_data   (mem_rdata),
        .tag_we    (tag_we),
        .wr_tag    (base_addr[31 -: TAG_W]),
        .flush_all (flush_all)
    );

    // NOTE: every output is given a default before the case so no path can infer a latch.
    always_comb begin
        next_state  = state;
        hit         = 1'b0;
        instruction = '0;
        mem_req     = 1'b0;
        mem_addr    = pc;
        wr_en       = 1'b0;
        tag_we      = 1'b0;
        flush_all   = 1'b0;
        start_miss  = 1'b0;
        case (state)
            IDLE: begin
                flush_all = flush;
                if (cache_en) begin
                    hit         = lookup_hit;
                    instruction = lookup_hit ? lookup_data : '0;
                    if (!lookup_hit) begin
                        start_miss = 1'b1;
                        next_state = REFILL;
                    end
                end else begin
                    instruction = mem_rdata;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = base_addr | (32'(word_cnt) << 2);
                if (mem_ready) begin
                    wr_en = 1'b1;
                    if (word_cnt == OFF_W'(BLOCK_WORDS - 1)) begin
                        tag_we     = 1'b1;
                        next_state = FILL_DONE;
                    end
                end
            end
            FILL_DONE: begin
                // Deferred flush lands on the way back to IDLE, so the fresh line is dropped too.
                flush_all  = flush_pend || flush;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            word_cnt   <= '0;
            base_addr  <= '0;
            flush_pend <= 1'b0;
        end else begin
            state <= next_state;
            if (start_miss) begin
                base_addr <= {pc[31:2+OFF_W], {(OFF_W+2){1'b0}}};
                word_cnt  <= '0;
            end else if (wr_en) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (state == FILL_DONE) begin
                flush_pend <= 1'b0;
            end else if (state == REFILL && flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: vector table for steady-state lookups plus refill/flush/reset sequences.
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        cache_en;
    logic        flush;
    logic [31:0] instruction;
    logic        hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int lat = 1;
    int wait_cnt = 0;
    logic [31:0] acc_q[$];

    icache_ctrl #(.LINES(8), .BLOCK_WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .cache_en    (cache_en),
        .flush       (flush),
        .instruction (instruction),
        .hit         (hit),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    // Zero-latency read data for whatever address is presented.
    assign mem_rdata = mem_word(mem_addr);

    // Responder: asserts mem_ready on the lat-th cycle of each pending request.
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (wait_cnt >= lat - 1) begin
                    mem_ready = 1'b1;
                    wait_cnt  = 0;
                end else begin
                    mem_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
            end
        end
    end

    // Record every accepted refill word and when it was accepted.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst && mem_req && mem_ready) begin
                acc_q.push_back(mem_addr);
                last_acc_cyc = cyc;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Present a missing line address, then follow its refill until the lookup hits.
    task automatic fill_line(input logic [31:0] addr);
        bit got = 1'b0;
        acc_q.delete();
        at_neg();
        pc = addr; cache_en = 1'b1; flush = 1'b0;
        #1;
        check("miss_hit", 32'(hit), 32'd0);
        check("miss_instr", instruction, 32'd0);
        check("miss_req_idle", 32'(mem_req), 32'd0);
        at_neg(); #1;
        check("refill_req", 32'(mem_req), 32'd1);
        check("refill_first_addr", mem_addr, addr);
        for (int i = 0; i < 200 && !got; i++) begin
            if (hit) got = 1'b1;
            else begin at_neg(); #1; end
        end
        check("refill_done", 32'(got), 32'd1);
        check("refill_words", 32'(acc_q.size()), 32'd4);
        for (int w = 0; w < 4; w++) begin
            if (w < acc_q.size()) check("refill_order", acc_q[w], addr + 32'(w * 4));
        end
        check("hit_latency", 32'(cyc - last_acc_cyc), 32'd1);
        check("hit_instr", instruction, mem_word(addr));
    endtask

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        en;
        logic        fl;
        logic        exp_hit;
        logic [31:0] exp_instr;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"hit_44",     32'h44,  1'b1, 1'b0, 1'b1, mem_word(32'h44),  1'b0, 32'h44};
        vecs[1] = '{"hit_4c",     32'h4C,  1'b1, 1'b0, 1'b1, mem_word(32'h4C),  1'b0, 32'h4C};
        vecs[2] = '{"bypass_100", 32'h100, 1'b0, 1'b0, 1'b0, mem_word(32'h100), 1'b0, 32'h100};
        vecs[3] = '{"bypass_48",  32'h48,  1'b0, 1'b0, 1'b0, mem_word(32'h48),  1'b0, 32'h48};
        vecs[4] = '{"hit_40",     32'h40,  1'b1, 1'b0, 1'b1, mem_word(32'h40),  1'b0, 32'h40};
        vecs[5] = '{"flush_same", 32'h48,  1'b1, 1'b1, 1'b1, mem_word(32'h48),  1'b0, 32'h48};

        rst = 1'b1; pc = 32'h40; cache_en = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        at_neg();
        rst = 1'b0;
        #1;
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_bypass_instr", instruction, mem_word(32'h40));
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'h40);

        // Cold miss at 0x40, single-cycle memory.
        fill_line(32'h40);

        // Steady-state lookups with slower memory; last vector flushes while hitting.
        lat = 3;
        foreach (vecs[i]) begin
            at_neg();
            pc = vecs[i].pc; cache_en = vecs[i].en; flush = vecs[i].fl;
            #1;
            check({vecs[i].name, "_hit"},   32'(hit),     32'(vecs[i].exp_hit));
            check({vecs[i].name, "_instr"}, instruction,  vecs[i].exp_instr);
            check({vecs[i].name, "_req"},   32'(mem_req), 32'(vecs[i].exp_req));
            check({vecs[i].name, "_addr"},  mem_addr,     vecs[i].exp_addr);
        end

        // Flushed line misses again; then a conflicting line evicts it.
        fill_line(32'h40);
        fill_line(32'hC0);

        // Evicted 0x40 misses; flush mid-refill forces an immediate second refill.
        acc_q.delete();
        at_neg();
        pc = 32'h40; cache_en = 1'b1; flush = 1'b0;
        #1;
        check("evict_miss", 32'(hit), 32'd0);
        for (int i = 0; i < 100; i++) begin
            at_neg();
            if (acc_q.size() >= 1) break;
        end
        flush = 1'b1;
        at_neg();
        flush = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (acc_q.size() >= 4) break;
            at_neg();
        end
        #1;
        check("flush_words", 32'(acc_q.size()), 32'd4);
        check("fill_done_hit", 32'(hit), 32'd0);
        check("fill_done_req", 32'(mem_req), 32'd0);
        at_neg(); #1;
        check("flush_idle_hit", 32'(hit), 32'd0);
        check("flush_idle_req", 32'(mem_req), 32'd0);
        at_neg(); #1;
        check("rerefill_req", 32'(mem_req), 32'd1);
        check("rerefill_addr", mem_addr, 32'h40);
        begin
            bit got = 1'b0;
            for (int i = 0; i < 200 && !got; i++) begin
                if (hit) got = 1'b1;
                else begin at_neg(); #1; end
            end
            check("rerefill_hit", 32'(got), 32'd1);
            check("rerefill_instr", instruction, mem_word(32'h40));
        end

        // Earlier bypass at 0x100 must not have validated anything.
        fill_line(32'h100);

        // Reset after two accepted words abandons the refill.
        lat = 1;
        acc_q.delete();
        at_neg();
        pc = 32'h80; cache_en = 1'b1;
        #1;
        check("rst_seq_miss", 32'(hit), 32'd0);
        for (int i = 0; i < 100; i++) begin
            at_neg();
            if (acc_q.size() >= 2) break;
        end
        check("rst_seq_words", 32'(acc_q.size()), 32'd2);
        rst = 1'b1;
        at_neg();
        rst = 1'b0; cache_en = 1'b0;
        #1;
        check("rst_seq_req_drop", 32'(mem_req), 32'd0);
        fill_line(32'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
